// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the clk_div_ctrl clock divider.
package clk_div_pkg;

  localparam int CNT_W_DEF = 32;
  localparam int SEL_W     = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    STEP  = 2'd3
  } state_t;

  function automatic int half_sel(input logic [SEL_W-1:0] sel,
                                  input int h0, input int h1,
                                  input int h2, input int h3);
    case (sel)
      2'd0:    return h0;
      2'd1:    return h1;
      2'd2:    return h2;
      default: return h3;
    endcase
  endfunction

endpackage

// File: rtl/clk_div_ctrl_btn_sync_edge.sv
// Two-flop synchroniser for the step push button, followed by a registered
// rising-edge pulse (one clk_in cycle wide).
module btn_sync_edge (
  input  logic clk_in,
  input  logic rst_n,
  input  logic btn,
  output logic rise
);

  // [0],[1] synchroniser stages, [2] previous synchronised level
  logic [2:0] sync_q;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      rise   <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], btn};
      rise   <= sync_q[1] & ~sync_q[2];
    end
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// CPU clock divider with four selectable rates, run/halt and optional
// single-step (compile with CLK_DIV_STEP_EN to enable the step button).
//
// state | meaning
// IDLE  | clk_out held low, counter cleared
// RUN   | free-running divided clock
// DRAIN | run dropped while high; finish the high phase, then IDLE
// STEP  | one full period (low lead-in, high, low) from a button press
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int HALF0 = 2,
  parameter int HALF1 = 250000,
  parameter int HALF2 = 2500000,
  parameter int HALF3 = 25000000
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic [SEL_W-1:0] sel,
  input  logic             run,
  input  logic             step,
  output logic             clk_out,
  output logic             tick,
  output logic             busy
);

  localparam longint HALF_MAX = (longint'(1) << CNT_W) - 1;

  if (HALF0 < 1 || HALF1 < 1 || HALF2 < 1 || HALF3 < 1) begin : g_half_zero
    $error("clk_div_ctrl: every HALFk must be at least 1");
  end
  if (longint'(HALF0) > HALF_MAX || longint'(HALF1) > HALF_MAX ||
      longint'(HALF2) > HALF_MAX || longint'(HALF3) > HALF_MAX) begin : g_half_wide
    $error("clk_div_ctrl: a HALFk does not fit in CNT_W bits");
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] half_q;
  logic [CNT_W-1:0] half_nxt;
  logic             clk_q;
  logic             tick_q;
  logic             at_toggle;
  logic             step_edge;
  logic             step_fell_q;

  assign half_nxt  = CNT_W'(half_sel(sel, HALF0, HALF1, HALF2, HALF3));
  assign at_toggle = (cnt_q == half_q - CNT_W'(1));

`ifdef CLK_DIV_STEP_EN
  btn_sync_edge u_step_sync (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .btn    (step),
    .rise   (step_edge)
  );

  // Marks that the high phase of a step period is over; the next toggle
  // point then ends the trailing low phase instead of rising again.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n)                  step_fell_q <= 1'b0;
    else if (state_q != STEP)    step_fell_q <= 1'b0;
    else if (at_toggle && clk_q) step_fell_q <= 1'b1;
  end
`else
  logic unused_step;
  assign unused_step = step;
  assign step_edge   = 1'b0;
  assign step_fell_q = 1'b0;
`endif

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (run)            state_d = RUN;
        else if (step_edge) state_d = STEP;
      end
      RUN: begin
        // dropping run at the falling toggle needs no drain phase
        if (!run && (!clk_q || at_toggle)) state_d = IDLE;
        else if (!run)                     state_d = DRAIN;
      end
      DRAIN: begin
        if (run)            state_d = RUN;
        else if (at_toggle) state_d = IDLE;
      end
      STEP: begin
        if (at_toggle && step_fell_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      half_q <= CNT_W'(HALF0);
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      if (state_d == IDLE) begin
        cnt_q <= '0;
        clk_q <= 1'b0;
      end else if (state_q == IDLE) begin
        cnt_q  <= '0;
        half_q <= half_nxt;
      end else if (at_toggle) begin
        cnt_q  <= '0;
        half_q <= half_nxt;
        clk_q  <= ~clk_q;
        tick_q <= ~clk_q;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign clk_out = clk_q;
  assign tick    = tick_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl with HALF0..3 = 2, 3, 5, 8.
module tb_clk_div_ctrl;

  localparam int HALF_T [4] = '{2, 3, 5, 8};

  logic       clk_in, rst_n, run, step;
  logic [1:0] sel;
  logic       clk_out, tick, busy;

  int n_chk = 0;
  int n_err = 0;
  bit mdl_chk = 0;

  clk_div_ctrl #(
    .HALF0 (HALF_T[0]),
    .HALF1 (HALF_T[1]),
    .HALF2 (HALF_T[2]),
    .HALF3 (HALF_T[3])
  ) dut (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .sel     (sel),
    .run     (run),
    .step    (step),
    .clk_out (clk_out),
    .tick    (tick),
    .busy    (busy)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time ran out, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: a phase is "left" cycles long from now; the clock only
  // ever changes at the end of a phase, and stopping is allowed only from low.
  typedef struct packed {
    logic act;
    logic hi;
    logic tick;
    int   left;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t mdl_next(mdl_t cur, logic run_i, logic [1:0] sel_i);
    mdl_t nx;
    nx = cur;
    nx.tick = 1'b0;
    if (!cur.act) begin
      nx.hi = 1'b0;
      if (run_i) begin
        nx.act  = 1'b1;
        nx.left = HALF_T[sel_i];
      end
    end else if (!run_i && (!cur.hi || cur.left == 1)) begin
      nx = '{act: 1'b0, hi: 1'b0, tick: 1'b0, left: 0};
    end else if (cur.left == 1) begin
      nx.hi   = !cur.hi;
      nx.tick = !cur.hi;
      nx.left = HALF_T[sel_i];
    end else begin
      nx.left = cur.left - 1;
    end
    return nx;
  endfunction

  always @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else        m <= mdl_next(m, run, sel);
  end

  always @(negedge clk_in) begin
    if (mdl_chk && rst_n) begin
      chk("mdl_clk_out", int'(clk_out), int'(m.hi));
      chk("mdl_tick",    int'(tick),    int'(m.tick));
      chk("mdl_busy",    int'(busy),    int'(m.act));
    end
  end

  task automatic do_reset();
    @(negedge clk_in);
    rst_n = 1'b0;
    run   = 1'b0;
    step  = 1'b0;
    repeat (2) @(negedge clk_in);
    rst_n = 1'b1;
  endtask

  // Cycles until clk_out next differs from its current sampled value.
  task automatic next_toggle(output int n);
    logic v;
    v = clk_out;
    n = 0;
    do begin
      @(negedge clk_in);
      n++;
    end while (clk_out == v && n < 100);
    if (clk_out == v) begin
      n_chk++;
      n_err++;
      $display("FAIL toggle_timeout: clk_out stuck at %0d, required a change within 100 cycles", v);
    end
  endtask

  typedef struct {
    logic       run;
    logic [1:0] sel;
    logic       clk;
    logic       tck;
    logic       bsy;
  } vec_t;

  vec_t tbl [12];

  initial begin
    int n;
    int rise_idx, hi_cnt, tick_cnt, busy_cnt, exp_on;
    logic [39:0] s_clk, s_tick, s_busy;

`ifdef CLK_DIV_STEP_EN
    exp_on = 1;
`else
    exp_on = 0;
`endif

    // run=1 from IDLE at sel=0: rise every 4 cycles starting at edge 2
    for (int i = 0; i < 12; i++) begin
      tbl[i].run = 1'b1;
      tbl[i].sel = 2'd0;
      tbl[i].clk = (i >= 2) && (((i - 2) % 4) < 2);
      tbl[i].tck = (i >= 2) && (((i - 2) % 4) == 0);
      tbl[i].bsy = 1'b1;
    end

    rst_n = 1'b0;
    run   = 1'b0;
    step  = 1'b0;
    sel   = 2'd0;
    repeat (3) @(negedge clk_in);
    chk("reset_clk_out", int'(clk_out), 0);
    chk("reset_busy", int'(busy), 0);
    rst_n = 1'b1;
    mdl_chk = 1;

    for (int i = 0; i < 50; i++) begin
      @(negedge clk_in);
      chk("idle_outputs", int'({clk_out, tick, busy}), 0);
    end

    do_reset();
    for (int i = 0; i < 12; i++) begin
      run = tbl[i].run;
      sel = tbl[i].sel;
      @(negedge clk_in);
      chk("tbl_clk_out", int'(clk_out), int'(tbl[i].clk));
      chk("tbl_tick",    int'(tick),    int'(tbl[i].tck));
      chk("tbl_busy",    int'(busy),    int'(tbl[i].bsy));
    end

    // rate change from 3 to 8 one cycle into a high phase
    do_reset();
    sel = 2'd1;
    run = 1'b1;
    next_toggle(n);
    chk("run_to_rise", n - 1, 3);
    @(negedge clk_in);
    sel = 2'd3;
    next_toggle(n);
    chk("hi_len_at_sel_change", n + 1, 3);
    next_toggle(n);
    chk("lo_len_sel3", n, 8);
    next_toggle(n);
    chk("hi_len_sel3", n, 8);

    // run dropped at cnt=1 of a 5-cycle high phase, then while low
    do_reset();
    sel = 2'd2;
    run = 1'b1;
    next_toggle(n);
    @(negedge clk_in);
    run = 1'b0;
    next_toggle(n);
    chk("drain_hi_len", n + 1, 5);
    chk("drain_busy", int'(busy), 0);
    run = 1'b1;
    next_toggle(n);
    next_toggle(n);
    run = 1'b0;
    @(negedge clk_in);
    chk("low_stop_busy", int'(busy), 0);
    chk("low_stop_clk_out", int'(clk_out), 0);

    // randomised run/sel traffic against the model
    do_reset();
    repeat (600) begin
      @(negedge clk_in);
      if ($urandom_range(0, 7) == 0) run = ~run;
      if ($urandom_range(0, 3) == 0) sel = 2'($urandom_range(0, 3));
    end

    // single step at sel=2 with a second press inside the period
    do_reset();
    mdl_chk = 0;
    sel  = 2'd2;
    step = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_in);
      s_clk[i]  = clk_out;
      s_tick[i] = tick;
      s_busy[i] = busy;
      if (i == 2)  step = 1'b0;
      if (i == 10) step = 1'b1;
      if (i == 12) step = 1'b0;
    end
    rise_idx = -1;
    hi_cnt = 0;
    tick_cnt = 0;
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (s_clk[i] && rise_idx < 0) rise_idx = i;
      hi_cnt   += int'(s_clk[i]);
      tick_cnt += int'(s_tick[i]);
      busy_cnt += int'(s_busy[i]);
    end
    chk("step_rise_latency", rise_idx, exp_on ? 8 : -1);
    chk("step_hi_len", hi_cnt, exp_on ? 5 : 0);
    chk("step_tick_count", tick_cnt, exp_on ? 1 : 0);
    chk("step_tick_at_rise", int'(s_tick[8]), exp_on);
    chk("step_busy_cycles", busy_cnt, exp_on ? 15 : 0);
    chk("step_busy_last", int'(s_busy[17]), exp_on);
    chk("step_busy_end", int'(s_busy[18]), 0);

    // reset asserted during the high phase of a step
    @(negedge clk_in);
    step = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_in);
      if (i == 2) step = 1'b0;
    end
    chk("step_hi_before_rst", int'(clk_out), exp_on);
    rst_n = 1'b0;
    #1;
    chk("rst_async_clk_out", int'(clk_out), 0);
    chk("rst_async_busy", int'(busy), 0);
    @(negedge clk_in);
    rst_n = 1'b1;
    mdl_chk = 1;
    hi_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_in);
      hi_cnt += int'(clk_out) + int'(busy) + int'(tick);
    end
    chk("post_rst_no_residual", hi_cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
